spybuffer_output_merger: RTL

//  Drains the N output SpyBuffers of a test top level and serialises their words into one

---
 rtl/spybuffer_merger_pkg.sv | 47 ++++
 rtl/spybuffer_output_merger_rr_select.sv | 37 +++
 rtl/spybuffer_output_merger.sv | 139 +++++++++++++
 3 files changed

// File: rtl/spybuffer_merger_pkg.sv
// Shared types and helpers for the spybuffer output merger: FSM states and the
// round-robin search used to pick the next spybuffer to drain.
package spybuffer_merger_pkg;

    localparam int MAX_INPUTS = 16;
    localparam int IDX_WIDTH  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        VALID = 2'd2
    } merger_state_t;

    typedef struct packed {
        logic                 found;
        logic [IDX_WIDTH-1:0] idx;
    } rr_pick_t;

    // Width of a source index; a single input still gets a 1-bit tag.
    function automatic int src_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First set bit of mask at or after start, wrapping at n. Walks offsets from
    // the far end so the nearest candidate is the last one written.
    function automatic rr_pick_t rr_next(input logic [MAX_INPUTS-1:0] mask,
                                         input logic [IDX_WIDTH-1:0]  start,
                                         input int                    n);
        rr_pick_t pick;
        int       cand;
        pick = '0;
        for (int off = MAX_INPUTS - 1; off >= 0; off--) begin
            if (off < n) begin
                cand = int'(start) + off;
                if (cand >= n) begin
                    cand = cand - n;
                end
                if (mask[cand]) begin
                    pick.found = 1'b1;
                    pick.idx   = cand[IDX_WIDTH-1:0];
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/spybuffer_output_merger_rr_select.sv
// Combinational round-robin picker: lowest-distance set bit of mask starting at
// start, wrapping over N_INPUTS entries.
module rr_select
    import spybuffer_merger_pkg::*;
#(
    parameter int N_INPUTS  = 4,
    parameter int SRC_WIDTH = 2
) (
    input  logic [N_INPUTS-1:0]  mask,
    input  logic [SRC_WIDTH-1:0] start,
    output logic [SRC_WIDTH-1:0] idx,
    output logic                 found
);

    logic [MAX_INPUTS-1:0] mask_ext;
    logic [IDX_WIDTH-1:0]  start_ext;
    rr_pick_t              pick;

    genvar gi;
    generate
        for (gi = 0; gi < MAX_INPUTS; gi++) begin : g_mask
            if (gi < N_INPUTS) begin : g_used
                assign mask_ext[gi] = mask[gi];
            end else begin : g_unused
                assign mask_ext[gi] = 1'b0;
            end
        end
    endgenerate

    assign start_ext = IDX_WIDTH'(start);
    assign pick      = rr_next(mask_ext, start_ext, N_INPUTS);

    // The range guard keeps every bit of the pick meaningful for narrow tags.
    assign found = pick.found && (int'(pick.idx) < N_INPUTS);
    assign idx   = pick.idx[SRC_WIDTH-1:0];

endmodule

// File: rtl/spybuffer_output_merger.sv
// Drains N output spybuffers round-robin into one valid/ready stream tagged with
// the source index, and counts delivered words per source.
module spybuffer_output_merger
    import spybuffer_merger_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int N_INPUTS   = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [N_INPUTS*DATA_WIDTH-1:0] in_data,
    input  logic [N_INPUTS-1:0]            in_empty,
    output logic [N_INPUTS-1:0]            in_read_enable,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [src_width(N_INPUTS)-1:0] out_src,
    output logic                           out_valid,
    input  logic                           out_ready,
    input  logic                           clear_counts,
    output logic [N_INPUTS*CNT_WIDTH-1:0]  word_count
);

    localparam int                   SRC_WIDTH = src_width(N_INPUTS);
    localparam logic [SRC_WIDTH-1:0] LAST_IDX  = SRC_WIDTH'(N_INPUTS - 1);

    logic [1:0]            rst_pipe_reg;
    logic                  rst_sync_n;
    merger_state_t         state_reg;
    logic                  run_reg;
    logic [SRC_WIDTH-1:0]  sel_reg;
    logic [SRC_WIDTH-1:0]  rr_ptr_reg;
    logic [SRC_WIDTH-1:0]  sel_inc;
    logic [SRC_WIDTH-1:0]  pick_start;
    logic [SRC_WIDTH-1:0]  pick_idx;
    logic                  pick_found;
    logic                  handshake;
    logic                  launch;
    logic [DATA_WIDTH-1:0] sel_word;

    // Reset takes effect immediately but is released on a clock edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rst_pipe_reg <= '0;
        end else begin
            rst_pipe_reg <= {rst_pipe_reg[0], 1'b1};
        end
    end
    assign rst_sync_n = rst_pipe_reg[1];

    assign sel_inc    = (sel_reg == LAST_IDX) ? '0 : sel_reg + 1'b1;
    assign handshake  = (state_reg == VALID) && out_valid && out_ready;
    assign pick_start = (state_reg == VALID) ? sel_inc : rr_ptr_reg;

    rr_select #(
        .N_INPUTS  (N_INPUTS),
        .SRC_WIDTH (SRC_WIDTH)
    ) u_rr_select (
        .mask  (~in_empty),
        .start (pick_start),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // run_reg holds strobes off until the first clock after reset release.
    assign launch = run_reg && pick_found && ((state_reg == IDLE) || handshake);

    always_comb begin
        sel_word = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            if (sel_reg == SRC_WIDTH'(i)) begin
                sel_word = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clock or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_reg  <= IDLE;
            run_reg    <= 1'b0;
            sel_reg    <= '0;
            rr_ptr_reg <= '0;
            out_data   <= '0;
            out_src    <= '0;
            out_valid  <= 1'b0;
        end else begin
            run_reg <= 1'b1;
            case (state_reg)
                IDLE: begin
                    if (launch) begin
                        sel_reg   <= pick_idx;
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    out_data  <= sel_word;
                    out_src   <= sel_reg;
                    out_valid <= 1'b1;
                    state_reg <= VALID;
                end
                VALID: begin
                    if (out_ready) begin
                        rr_ptr_reg <= sel_inc;
                        out_valid  <= 1'b0;
                        if (launch) begin
                            sel_reg   <= pick_idx;
                            state_reg <= WAIT;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_INPUTS; gi++) begin : g_input
            logic [CNT_WIDTH-1:0] count_reg;

            assign in_read_enable[gi] = launch && (pick_idx == SRC_WIDTH'(gi));

            // Saturating; a clear in the same cycle as a handshake wins.
            always_ff @(posedge clock or negedge rst_sync_n) begin
                if (!rst_sync_n) begin
                    count_reg <= '0;
                end else if (clear_counts) begin
                    count_reg <= '0;
                end else if (handshake && (sel_reg == SRC_WIDTH'(gi)) && (count_reg != '1)) begin
                    count_reg <= count_reg + 1'b1;
                end
            end

            assign word_count[gi*CNT_WIDTH +: CNT_WIDTH] = count_reg;
        end
    endgenerate

endmodule
